// File: rtl/cntr8.sv
// 8-bit loadable up/down counter with a six-state step-selecting FSM.
// Two 4-bit carry look-ahead slices add the step (+1, +2, -1, -2) to the count.

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is flattened to generate/propagate terms, so no carry ripples inside the slice.
    assign c[0] = ci_i;
    assign c[1] = g[0] | (p[0] & ci_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci_i);
    assign co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci_i);

    assign s_o = p ^ c;
endmodule

module cntr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic [2:0] o_state,
    output logic       o_wrap
);
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_INC  = 3'b010,
        S_INC2 = 3'b011,
        S_DEC  = 3'b100,
        S_DEC2 = 3'b101
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       wrap_q, wrap_d;

    logic [7:0] step;
    logic [7:0] sum;
    logic       carry_lo;
    logic       carry_hi;

    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin
        state_d = S_IDLE;
        if (load) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: state_d = inc ? S_INC  : S_DEC;
                S_INC:          state_d = inc ? S_INC2 : S_DEC;
                S_INC2:         state_d = inc ? S_INC  : S_DEC;
                S_DEC:          state_d = inc ? S_INC  : S_DEC2;
                S_DEC2:         state_d = inc ? S_INC  : S_DEC;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Down steps are two's-complement adds; the borrow is the inverted carry-out.
    always_comb begin
        step = 8'h00;
        case (state_d)
            S_INC:   step = 8'h01;
            S_INC2:  step = 8'h02;
            S_DEC:   step = 8'hFF;
            S_DEC2:  step = 8'hFE;
            default: step = 8'h00;
        endcase
    end

    cla4 u_cla_lo (
        .a_i  (count_q[3:0]),
        .b_i  (step[3:0]),
        .ci_i (1'b0),
        .s_o  (sum[3:0]),
        .co_o (carry_lo)
    );

    cla4 u_cla_hi (
        .a_i  (count_q[7:4]),
        .b_i  (step[7:4]),
        .ci_i (carry_lo),
        .s_o  (sum[7:4]),
        .co_o (carry_hi)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        case (state_d)
            S_LOAD:        count_d = d_in;
            S_INC, S_INC2: begin
                count_d = sum;
                wrap_d  = carry_hi;
            end
            S_DEC, S_DEC2: begin
                count_d = sum;
                wrap_d  = ~carry_hi;
            end
            default: begin
                count_d = count_q;
                wrap_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 8'h00;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign d_out   = count_q;
    assign o_state = state_q;
    assign o_wrap  = wrap_q;
endmodule

// File: tb/tb_cntr8.sv
// Scoreboard bench for cntr8: stimulus pushes expected {d_out, o_state, o_wrap},
// a monitor pops and compares one entry after every rising edge.

module tb_cntr8;
    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] INC  = 3'b010;
    localparam logic [2:0] INC2 = 3'b011;
    localparam logic [2:0] DEC  = 3'b100;
    localparam logic [2:0] DEC2 = 3'b101;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic       w;
    } resp_t;

    typedef struct packed {
        logic       ld;
        logic       up;
        logic [7:0] din;
        logic [7:0] ed;
        logic [2:0] es;
        logic       ew;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       inc;
    logic       load;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic [2:0] o_state;
    logic       o_wrap;

    int n_tests = 0;
    int n_fail  = 0;

    resp_t exp_q[$];
    string name_q[$];

    int         m_d;
    logic [2:0] m_s;
    logic       m_w;

    cntr8 dut (
        .clk     (clk),
        .reset   (reset),
        .inc     (inc),
        .load    (load),
        .d_in    (d_in),
        .d_out   (d_out),
        .o_state (o_state),
        .o_wrap  (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input resp_t act, input resp_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got d_out=%02h state=%03b wrap=%b, expected d_out=%02h state=%03b wrap=%b",
                     name, act.d, act.s, act.w, exp.d, exp.s, exp.w);
        end
    endtask

    // Behavioural reference: integer arithmetic, wrap when the result leaves 0..255.
    task automatic model_step(input logic ld, input logic up, input logic [7:0] din);
        int delta;
        int sum;
        if (ld) m_s = LOAD;
        else begin
            case (m_s)
                IDLE, LOAD: m_s = up ? INC  : DEC;
                INC:        m_s = up ? INC2 : DEC;
                INC2:       m_s = up ? INC  : DEC;
                DEC:        m_s = up ? INC  : DEC2;
                DEC2:       m_s = up ? INC  : DEC;
                default:    m_s = IDLE;
            endcase
        end
        case (m_s)
            INC:     delta = 1;
            INC2:    delta = 2;
            DEC:     delta = -1;
            DEC2:    delta = -2;
            default: delta = 0;
        endcase
        if (m_s == LOAD) begin
            m_d = int'(din);
            m_w = 1'b0;
        end else begin
            sum = m_d + delta;
            m_w = (m_s != IDLE) && (sum > 255 || sum < 0);
            m_d = (sum + 256) % 256;
        end
    endtask

    task automatic drive(input logic ld, input logic up, input logic [7:0] din,
                         input resp_t exp, input string name);
        @(negedge clk);
        load = ld;
        inc  = up;
        d_in = din;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check(name_q.pop_front(), resp_t'({d_out, o_state, o_wrap}), exp_q.pop_front());
        end
    end

    vec_t vecs[19];

    initial begin : stimulus
        logic       r_ld;
        logic       r_up;
        logic [7:0] r_din;
        int         budget;

        vecs = '{
            '{1'b1, 1'b1, 8'hA5, 8'hA5, LOAD, 1'b0},
            '{1'b1, 1'b1, 8'h00, 8'h00, LOAD, 1'b0},
            '{1'b0, 1'b1, 8'h00, 8'h01, INC,  1'b0},
            '{1'b0, 1'b1, 8'h00, 8'h03, INC2, 1'b0},
            '{1'b0, 1'b1, 8'h00, 8'h04, INC,  1'b0},
            '{1'b0, 1'b1, 8'h00, 8'h06, INC2, 1'b0},
            '{1'b0, 1'b0, 8'h00, 8'h05, DEC,  1'b0},
            '{1'b0, 1'b0, 8'h00, 8'h03, DEC2, 1'b0},
            '{1'b0, 1'b1, 8'h00, 8'h04, INC,  1'b0},
            '{1'b1, 1'b0, 8'h01, 8'h01, LOAD, 1'b0},
            '{1'b0, 1'b0, 8'h00, 8'h00, DEC,  1'b0},
            '{1'b0, 1'b0, 8'h00, 8'hFE, DEC2, 1'b1},
            '{1'b0, 1'b0, 8'h00, 8'hFD, DEC,  1'b0},
            '{1'b1, 1'b1, 8'hFE, 8'hFE, LOAD, 1'b0},
            '{1'b0, 1'b1, 8'h00, 8'hFF, INC,  1'b0},
            '{1'b0, 1'b1, 8'h00, 8'h01, INC2, 1'b1},
            '{1'b1, 1'b0, 8'h00, 8'h00, LOAD, 1'b0},
            '{1'b0, 1'b0, 8'h00, 8'hFF, DEC,  1'b1},
            '{1'b0, 1'b1, 8'h00, 8'h00, INC,  1'b1}
        };

        reset = 1'b1;
        inc   = 1'b0;
        load  = 1'b0;
        d_in  = 8'h00;
        m_d   = 0;
        m_s   = IDLE;
        m_w   = 1'b0;
        #2;
        check("reset_state", resp_t'({d_out, o_state, o_wrap}), resp_t'({8'h00, IDLE, 1'b0}));
        @(negedge clk);
        reset = 1'b0;

        drive(1'b1, 1'b0, 8'h37, resp_t'({8'h37, LOAD, 1'b0}), "load_37");
        model_step(1'b1, 1'b0, 8'h37);
        @(negedge clk);
        load = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", resp_t'({d_out, o_state, o_wrap}), resp_t'({8'h00, IDLE, 1'b0}));
        @(posedge clk);
        #1;
        check("reset_held", resp_t'({d_out, o_state, o_wrap}), resp_t'({8'h00, IDLE, 1'b0}));
        @(negedge clk);
        reset = 1'b0;
        m_d = 0;
        m_s = IDLE;
        m_w = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].up, vecs[i].din,
                  resp_t'({vecs[i].ed, vecs[i].es, vecs[i].ew}), $sformatf("vec%0d", i));
            model_step(vecs[i].ld, vecs[i].up, vecs[i].din);
        end

        for (int i = 0; i < 1000; i++) begin
            r_ld  = ($urandom_range(0, 7) == 0);
            r_up  = $urandom_range(0, 1) == 1;
            r_din = 8'($urandom_range(0, 255));
            model_step(r_ld, r_up, r_din);
            drive(r_ld, r_up, r_din, resp_t'({8'(m_d), m_s, m_w}), $sformatf("rand%0d", i));
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
